ras_ckpt: RTL and testbench
===========================

# ras_ckpt

Parametrised return address stack for the fetch predictor. It generalises the fixed 8-entry RAS to configurable depth and target width. It adds per-entry recursion counters, occupancy tracking, and single-cycle checkpoint restore on mispredict. It sits beside the BTB/UPCT in the fetch predictor: call-type predictions push, return-type predictions pop, and the backend restore port repairs state on redirect.

## Interface
Parameters:
- RAS_ENTRIES, 8: stack depth; power of two, ≥2.
- RAS_TARGET_WIDTH, 31: stored target width (PC[31:1]).
- RAS_CNT_WIDTH, 3: recursion counter width per entry.
- LOG_RAS_ENTRIES, $clog2(RAS_ENTRIES): pointer width.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST  in  1  reset, asynchronous, active-high.
- link_valid  in  1  push request from a predicted call.
- link_target  in  RAS_TARGET_WIDTH  return address to push.
- ret_valid  in  1  pop request from a predicted return.
- ret_target  out  RAS_TARGET_WIDTH  top-of-stack target; combinational from state.
- ret_target_valid  out  1  occupancy != 0.
- ckpt  out  LOG_RAS_ENTRIES+RAS_CNT_WIDTH+LOG_RAS_ENTRIES+1  current {ptr, top_cnt, occ}; the front-end stores this with each prediction.
- restore_valid  in  1  mispredict repair.
- restore_ckpt  in  same width as ckpt  checkpoint to restore.
- restore_link_valid, restore_link_target, restore_ret_valid  in  1/RAS_TARGET_WIDTH/1  call/return action of the mispredicted instruction, applied after restore.

## Operation
- State:
  - entry[i] = {target, cnt}
  - ptr: index of the top entry.
  - occ: 0..RAS_ENTRIES.
- Reset: all entries {0,0}, ptr=0, occ=0. Outputs: ret_target=0, ret_target_valid=0, ckpt=0.
- Push only:
  - Merge case: occ≠0, entry[ptr].target==link_target and cnt<max. Increment cnt; ptr and occ unchanged.
  - Otherwise: ptr=ptr+1 (mod RAS_ENTRIES), write {link_target,0}, occ=min(occ+1,RAS_ENTRIES).
  - A full stack wraps and overwrites the oldest entry silently.
- Pop only:
  - If cnt>0: cnt=cnt-1.
  - Else: ptr=ptr-1 (mod), occ=max(occ-1,0).
  - A pop with occ=0 still moves ptr (stale prediction allowed) and occ stays 0.
- Push+pop same cycle (coroutine swap):
  - If top cnt==0: overwrite entry[ptr] with {link_target,0}; ptr unchanged; occ=max(occ,1).
  - If top cnt>0: decrement cnt, then perform a non-merging push to ptr+1.
- Restore:
  - Has priority over link_valid/ret_valid; those are ignored in a restore cycle.
  - Sets ptr, occ, and entry[ptr].cnt from restore_ckpt. Targets are untouched.
  - Then applies restore_link/restore_ret to the restored state with the push/pop/swap rules above, all in the same cycle.
- Entries below the restored ptr may have been overwritten since the checkpoint was taken. This is accepted inaccuracy and is not detected.

## Timing
- 0-cycle read: ret_target, ret_target_valid and ckpt reflect the state registered at the last edge.
- 1-cycle update: push, pop and restore effects are visible the cycle after assertion.
- Back-to-back push/pop every cycle is supported with no bubbles.
- Pointer arithmetic is modulo RAS_ENTRIES with natural wrap. The cnt increment saturates at 2^RAS_CNT_WIDTH-1; at saturation the push allocates a new entry instead of merging.
- RST asserted mid-operation clears all state immediately (asynchronous). The first push after deassertion writes entry[1].

## Structure
- Add to core_types_pkg:
  - RAS_CNT_WIDTH.
  - RAS_CKPT_WIDTH.
  - typedef ras_entry_t {target, cnt}.
  - typedef ras_ckpt_t {ptr, top_cnt, occ}.
- The existing RAS_ENTRIES and RAS_TARGET_WIDTH feed the parameter defaults.
- Single module, no sub-module. A shared next-state function applies the push/pop/swap rules to both the normal path and the post-restore path.

## Test plan
- Reset, then push 0x100 -> next cycle ret_target=0x100, ret_target_valid=1, ckpt={1,0,1}; pop -> ret_target_valid=0, ptr=0.
- Push 0x200 three times -> single entry with cnt=2, occ=1. Three pops -> ret_target=0x200 until the third pop, then occ=0.
- Push 9 distinct targets 0x1..0x9 (depth 8) -> occ=8, wrap overwrote entry[1]. 8 pops return 0x9..0x2; 9th pop returns stale 0x9 with ret_target_valid=0.
- Push 0x10 then assert push 0x20 + pop in the same cycle -> ret_target=0x20, occ=1, ptr unchanged.
- Push 0xA, save ckpt, push 0xB, 0xC, then restore with the saved ckpt and restore_ret_valid=1 -> next cycle occ=0, ret_target_valid=0. The same restore with restore_link 0xD instead -> top 0xD, occ=2.
- Assert RST asynchronously mid-push -> outputs clear before the next edge; no push takes effect.

Source files
------------

// File: rtl/ras_ckpt_pkg.sv
// Shared types and default sizing for the checkpointed return address stack.
package ras_ckpt_pkg;

  localparam int unsigned RAS_ENTRIES      = 8;
  localparam int unsigned RAS_TARGET_WIDTH = 31;
  localparam int unsigned RAS_CNT_WIDTH    = 3;
  localparam int unsigned LOG_RAS_ENTRIES  = $clog2(RAS_ENTRIES);
  localparam int unsigned RAS_CKPT_WIDTH   = 2 * LOG_RAS_ENTRIES + RAS_CNT_WIDTH + 1;

  typedef struct packed {
    logic [RAS_TARGET_WIDTH-1:0] target;
    logic [RAS_CNT_WIDTH-1:0]    cnt;
  } ras_entry_t;

  typedef struct packed {
    logic [LOG_RAS_ENTRIES-1:0] ptr;
    logic [RAS_CNT_WIDTH-1:0]   top_cnt;
    logic [LOG_RAS_ENTRIES:0]   occ;
  } ras_ckpt_t;

endpackage

// File: rtl/ras_ckpt.sv
// Return address stack with recursion counters, occupancy tracking and
// single-cycle checkpoint restore for mispredict repair.
module ras_ckpt #(
  parameter int unsigned RAS_ENTRIES      = ras_ckpt_pkg::RAS_ENTRIES,
  parameter int unsigned RAS_TARGET_WIDTH = ras_ckpt_pkg::RAS_TARGET_WIDTH,
  parameter int unsigned RAS_CNT_WIDTH    = ras_ckpt_pkg::RAS_CNT_WIDTH,
  parameter int unsigned LOG_RAS_ENTRIES  = $clog2(RAS_ENTRIES)
) (
  input  logic                                                 CLK,
  input  logic                                                 RST,
  input  logic                                                 link_valid,
  input  logic [RAS_TARGET_WIDTH-1:0]                          link_target,
  input  logic                                                 ret_valid,
  output logic [RAS_TARGET_WIDTH-1:0]                          ret_target,
  output logic                                                 ret_target_valid,
  output logic [2*LOG_RAS_ENTRIES+RAS_CNT_WIDTH:0]             ckpt,
  input  logic                                                 restore_valid,
  input  logic [2*LOG_RAS_ENTRIES+RAS_CNT_WIDTH:0]             restore_ckpt,
  input  logic                                                 restore_link_valid,
  input  logic [RAS_TARGET_WIDTH-1:0]                          restore_link_target,
  input  logic                                                 restore_ret_valid
);

  typedef logic [LOG_RAS_ENTRIES-1:0]  ptr_t;
  typedef logic [LOG_RAS_ENTRIES:0]    occ_t;
  typedef logic [RAS_CNT_WIDTH-1:0]    cnt_t;
  typedef logic [RAS_TARGET_WIDTH-1:0] tgt_t;

  typedef struct packed {
    ptr_t ptr;
    cnt_t top_cnt;
    occ_t occ;
  } ckpt_t;

  // Result of one push/pop/swap step applied to a base state.
  typedef struct packed {
    ptr_t ptr;
    occ_t occ;
    cnt_t top_cnt;
    logic ent_we;
    ptr_t ent_idx;
    tgt_t ent_tgt;
  } upd_t;

  localparam cnt_t CNT_MAX  = '1;
  localparam occ_t OCC_FULL = occ_t'(RAS_ENTRIES);

  tgt_t tgt_q [RAS_ENTRIES];
  cnt_t cnt_q [RAS_ENTRIES];
  ptr_t ptr_q;
  occ_t occ_q;

  ckpt_t rc;
  ptr_t  base_ptr;
  occ_t  base_occ;
  cnt_t  base_cnt;
  tgt_t  base_tgt;
  logic  op_push;
  logic  op_pop;
  tgt_t  op_tgt;
  upd_t  upd;

  function automatic upd_t next_state(input ptr_t ptr, input occ_t occ, input tgt_t top_tgt,
                                      input cnt_t top_cnt, input logic push, input tgt_t push_tgt,
                                      input logic pop);
    upd_t u;
    ptr_t ptr_inc;
    occ_t occ_inc;
    ptr_inc   = ptr + ptr_t'(1);
    occ_inc   = (occ == OCC_FULL) ? occ : occ + occ_t'(1);
    u.ptr     = ptr;
    u.occ     = occ;
    u.top_cnt = top_cnt;
    u.ent_we  = 1'b0;
    u.ent_idx = ptr_inc;
    u.ent_tgt = push_tgt;
    if (push && pop) begin
      if (top_cnt == '0) begin
        // Coroutine swap replaces the top in place.
        u.ent_we  = 1'b1;
        u.ent_idx = ptr;
        if (occ == '0) u.occ = occ_t'(1);
      end else begin
        u.top_cnt = top_cnt - cnt_t'(1);
        u.ent_we  = 1'b1;
        u.ptr     = ptr_inc;
        u.occ     = occ_inc;
      end
    end else if (push) begin
      if (occ != '0 && top_tgt == push_tgt && top_cnt != CNT_MAX) begin
        u.top_cnt = top_cnt + cnt_t'(1);
      end else begin
        u.ent_we = 1'b1;
        u.ptr    = ptr_inc;
        u.occ    = occ_inc;
      end
    end else if (pop) begin
      if (top_cnt != '0) begin
        u.top_cnt = top_cnt - cnt_t'(1);
      end else begin
        u.ptr = ptr - ptr_t'(1);
        if (occ != '0) u.occ = occ - occ_t'(1);
      end
    end
    return u;
  endfunction

  assign rc = restore_ckpt;

  // Restore substitutes the checkpointed state as the base for this cycle's action.
  always_comb begin
    base_ptr = ptr_q;
    base_occ = occ_q;
    base_cnt = cnt_q[ptr_q];
    op_push  = link_valid;
    op_pop   = ret_valid;
    op_tgt   = link_target;
    if (restore_valid) begin
      base_ptr = rc.ptr;
      base_occ = rc.occ;
      base_cnt = rc.top_cnt;
      op_push  = restore_link_valid;
      op_pop   = restore_ret_valid;
      op_tgt   = restore_link_target;
    end
    base_tgt = tgt_q[base_ptr];
    upd      = next_state(base_ptr, base_occ, base_tgt, base_cnt, op_push, op_tgt, op_pop);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ptr_q <= '0;
      occ_q <= '0;
      for (int unsigned i = 0; i < RAS_ENTRIES; i++) begin
        tgt_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      ptr_q           <= upd.ptr;
      occ_q           <= upd.occ;
      cnt_q[base_ptr] <= upd.top_cnt;
      if (upd.ent_we) begin
        tgt_q[upd.ent_idx] <= upd.ent_tgt;
        cnt_q[upd.ent_idx] <= '0;
      end
    end
  end

  assign ret_target       = tgt_q[ptr_q];
  assign ret_target_valid = (occ_q != '0);
  assign ckpt             = {ptr_q, cnt_q[ptr_q], occ_q};

endmodule

// File: tb/tb_ras_ckpt.sv
// Randomised and directed bench for ras_ckpt against an array-based stack model.
module tb_ras_ckpt;

  localparam int N    = 8;
  localparam int TW   = 31;
  localparam int CMAX = 7;

  logic          CLK;
  logic          RST;
  logic          link_valid;
  logic [TW-1:0] link_target;
  logic          ret_valid;
  logic [TW-1:0] ret_target;
  logic          ret_target_valid;
  logic [9:0]    ckpt;
  logic          restore_valid;
  logic [9:0]    restore_ckpt;
  logic          restore_link_valid;
  logic [TW-1:0] restore_link_target;
  logic          restore_ret_valid;

  ras_ckpt dut (
    .CLK(CLK), .RST(RST),
    .link_valid(link_valid), .link_target(link_target), .ret_valid(ret_valid),
    .ret_target(ret_target), .ret_target_valid(ret_target_valid), .ckpt(ckpt),
    .restore_valid(restore_valid), .restore_ckpt(restore_ckpt),
    .restore_link_valid(restore_link_valid), .restore_link_target(restore_link_target),
    .restore_ret_valid(restore_ret_valid)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  logic [TW-1:0] m_tgt [N];
  int            m_cnt [N];
  int            m_ptr;
  int            m_occ;
  int            hist [$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int m_ckpt();
    return m_ptr * 128 + m_cnt[m_ptr] * 16 + m_occ;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin
      m_tgt[i] = '0;
      m_cnt[i] = 0;
    end
    m_ptr = 0;
    m_occ = 0;
  endtask

  task automatic m_push_new(input logic [TW-1:0] t);
    m_ptr = (m_ptr + 1) % N;
    m_tgt[m_ptr] = t;
    m_cnt[m_ptr] = 0;
    m_occ = (m_occ + 1 > N) ? N : m_occ + 1;
  endtask

  task automatic m_apply(input bit push, input logic [TW-1:0] t, input bit pop);
    if (push && pop) begin
      if (m_cnt[m_ptr] == 0) begin
        m_tgt[m_ptr] = t;
        if (m_occ < 1) m_occ = 1;
      end else begin
        m_cnt[m_ptr] = m_cnt[m_ptr] - 1;
        m_push_new(t);
      end
    end else if (push) begin
      if (m_occ > 0 && m_tgt[m_ptr] == t && m_cnt[m_ptr] < CMAX) m_cnt[m_ptr] = m_cnt[m_ptr] + 1;
      else m_push_new(t);
    end else if (pop) begin
      if (m_cnt[m_ptr] > 0) m_cnt[m_ptr] = m_cnt[m_ptr] - 1;
      else begin
        m_ptr = (m_ptr + N - 1) % N;
        if (m_occ > 0) m_occ = m_occ - 1;
      end
    end
  endtask

  task automatic model_step();
    int rc;
    if (restore_valid) begin
      rc = int'(restore_ckpt);
      m_ptr = rc / 128;
      m_cnt[m_ptr] = (rc / 16) % 8;
      m_occ = rc % 16;
      m_apply(restore_link_valid, restore_link_target, restore_ret_valid);
    end else begin
      m_apply(link_valid, link_target, ret_valid);
    end
    hist.push_back(m_ckpt());
    if (hist.size() > 16) void'(hist.pop_front());
  endtask

  // Every-cycle comparison of DUT outputs against the model.
  initial begin
    forever begin
      @(negedge CLK);
      if (chk_en) begin
        check("ret_target", 64'(ret_target), 64'(m_tgt[m_ptr]));
        check("ret_target_valid", 64'(ret_target_valid), 64'(m_occ != 0));
        check("ckpt", 64'(ckpt), 64'(m_ckpt()));
      end
    end
  end

  task automatic clear_inputs();
    link_valid = 1'b0; link_target = '0; ret_valid = 1'b0;
    restore_valid = 1'b0; restore_ckpt = '0; restore_link_valid = 1'b0;
    restore_link_target = '0; restore_ret_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge CLK);
    if (!RST) model_step();
    #1;
  endtask

  task automatic op(input bit lv, input logic [TW-1:0] lt, input bit rv);
    link_valid = lv; link_target = lt; ret_valid = rv;
    tick();
    clear_inputs();
  endtask

  task automatic restore(input logic [9:0] c, input bit lv, input logic [TW-1:0] lt, input bit rv);
    restore_valid = 1'b1; restore_ckpt = c;
    restore_link_valid = lv; restore_link_target = lt; restore_ret_valid = rv;
    link_valid = 1'b1; link_target = 31'h7FF; ret_valid = 1'b1;
    tick();
    clear_inputs();
  endtask

  task automatic do_reset();
    RST = 1'b1;
    m_reset();
    #1;
    check("reset_target", 64'(ret_target), 64'h0);
    check("reset_valid", 64'(ret_target_valid), 64'h0);
    check("reset_ckpt", 64'(ckpt), 64'h0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  task automatic lit(input string name, input logic [TW-1:0] t, input bit v, input logic [9:0] c);
    check({name, "_target"}, 64'(ret_target), 64'(t));
    check({name, "_valid"}, 64'(ret_target_valid), 64'(v));
    check({name, "_ckpt"}, 64'(ckpt), 64'(c));
  endtask

  function automatic logic [TW-1:0] pick_target();
    case ($urandom_range(0, 3))
      0: return 31'h100;
      1: return 31'h200;
      2: return 31'h300;
      default: return TW'($urandom);
    endcase
  endfunction

  task automatic rand_cycle();
    int r;
    r = $urandom_range(0, 15);
    if (r < 2 && hist.size() > 0) begin
      restore(10'(hist[$urandom_range(0, hist.size() - 1)]), 1'($urandom_range(0, 1)),
              pick_target(), 1'($urandom_range(0, 1)));
    end else begin
      op(r < 10, pick_target(), (r >= 7));
    end
  endtask

  initial begin
    clear_inputs();
    RST = 1'b1;
    m_reset();
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    chk_en = 1'b1;
    lit("por", 31'h0, 1'b0, 10'h000);

    // Single push then pop.
    op(1'b1, 31'h100, 1'b0);
    lit("push1", 31'h100, 1'b1, 10'h081);
    op(1'b0, '0, 1'b1);
    lit("pop1", 31'h0, 1'b0, 10'h000);

    // Recursion merge: three pushes of the same target.
    do_reset();
    repeat (3) op(1'b1, 31'h200, 1'b0);
    lit("merge3", 31'h200, 1'b1, 10'h0A1);
    op(1'b0, '0, 1'b1);
    lit("mpop1", 31'h200, 1'b1, 10'h091);
    op(1'b0, '0, 1'b1);
    lit("mpop2", 31'h200, 1'b1, 10'h081);
    op(1'b0, '0, 1'b1);
    check("mpop3_valid", 64'(ret_target_valid), 64'h0);

    // Wrap: nine distinct targets into eight entries.
    do_reset();
    for (int i = 1; i <= 9; i++) op(1'b1, TW'(i), 1'b0);
    lit("wrap", 31'h9, 1'b1, 10'h088);
    check("model_occ_wrap", 64'(m_occ), 64'd8);
    for (int i = 0; i < 8; i++) begin
      check("wrap_pop_target", 64'(ret_target), 64'(9 - i));
      op(1'b0, '0, 1'b1);
    end
    lit("stale", 31'h9, 1'b0, 10'h080);

    // Coroutine swap.
    do_reset();
    op(1'b1, 31'h10, 1'b0);
    op(1'b1, 31'h20, 1'b1);
    lit("swap", 31'h20, 1'b1, 10'h081);

    // Counter saturation forces allocation.
    do_reset();
    repeat (9) op(1'b1, 31'h5, 1'b0);
    lit("sat", 31'h5, 1'b1, 10'h102);
    check("model_sat_cnt", 64'(m_cnt[1]), 64'd7);

    // Restore with a return, then with a call.
    do_reset();
    op(1'b1, 31'hA, 1'b0);
    op(1'b1, 31'hB, 1'b0);
    op(1'b1, 31'hC, 1'b0);
    restore(10'h081, 1'b0, '0, 1'b1);
    lit("rst_ret", 31'h0, 1'b0, 10'h000);
    do_reset();
    op(1'b1, 31'hA, 1'b0);
    op(1'b1, 31'hB, 1'b0);
    op(1'b1, 31'hC, 1'b0);
    restore(10'h081, 1'b1, 31'hD, 1'b0);
    lit("rst_link", 31'hD, 1'b1, 10'h102);

    // Asynchronous reset in the middle of a push.
    op(1'b1, 31'h44, 1'b0);
    link_valid = 1'b1; link_target = 31'h55;
    #2;
    RST = 1'b1;
    m_reset();
    #1;
    lit("async", 31'h0, 1'b0, 10'h000);
    @(posedge CLK);
    #1;
    lit("async_hold", 31'h0, 1'b0, 10'h000);
    clear_inputs();
    #2;
    RST = 1'b0;
    @(posedge CLK);
    #1;
    op(1'b1, 31'h77, 1'b0);
    lit("after_rst", 31'h77, 1'b1, 10'h081);

    // Randomised traffic including restores from recent checkpoints.
    for (int c = 0; c < 1500; c++) rand_cycle();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
